// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
package aes_pkg;

    // Number of expanded round keys after round 0 (AES-128 only).
    localparam int unsigned NUM_ROUNDS = 10;

    // First round constant of the key schedule.
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  round_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } kx_state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule handshake bundle: cipher key in, round keys out.
// master = key expander, slave = upstream key source / downstream consumer.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready_in;
    logic [127:0] key_out;
    logic         key_valid_out;
    round_t       key_round;
    logic         last_key;
    logic         busy;

    modport master (
        input  key_valid_in,
        input  key_in,
        input  key_ready_in,
        output key_out,
        output key_valid_out,
        output key_round,
        output last_key,
        output busy
    );

    modport slave (
        output key_valid_in,
        output key_in,
        output key_ready_in,
        input  key_out,
        input  key_valid_out,
        input  key_round,
        input  last_key,
        input  busy
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Kept standalone so the round stage can reuse it for SubBytes.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key and emits round keys
// 0..10 one per accepted handshake, holding each until it is taken.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS_P = NUM_ROUNDS
) (
    input  logic            clk,
    input  logic            reset,
    aes_key_expand_if.master kx
);

    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS_P);

    kx_state_t    state_q, state_d;
    logic [127:0] key_q,   key_d;
    round_t       round_q, round_d;
    logic [7:0]   rcon_q,  rcon_d;

    word_t        w0, w1, w2, w3;
    word_t        rot_w, sub_w, t_w;
    word_t        n0, n1, n2, n3;
    logic [127:0] next_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // RotWord: bytes (a,b,c,d) -> (b,c,d,a), MSB-first.
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (rot_w[8*g +: 8]),
            .data_o (sub_w[8*g +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon_q, 24'h0};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // State, key, round index and round constant registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Load in IDLE; advance one round per handshake in EMIT, finishing at the last round.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            ST_IDLE: begin
                if (kx.key_valid_in) begin
                    key_d   = kx.key_in;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (kx.key_ready_in) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + round_t'(1);
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign kx.key_out       = key_q;
    assign kx.key_valid_out = (state_q == ST_EMIT);
    assign kx.key_round     = round_q;
    assign kx.last_key      = (state_q == ST_EMIT) && (round_q == LAST_ROUND);
    assign kx.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    aes_key_expand_if kx_if ();

    aes_key_expand #(.NUM_ROUNDS_P(10)) dut (
        .clk   (clk),
        .reset (reset),
        .kx    (kx_if.master)
    );

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] exp_k [2][11] = '{
        '{128'h2b7e151628aed2a6abf7158809cf4f3c,
          128'ha0fafe1788542cb123a339392a6c7605,
          128'hf2c295f27a96b9435935807a7359f67f,
          128'h3d80477d4716fe3e1e237e446d7a883b,
          128'hef44a541a8525b7fb671253bdb0bad00,
          128'hd4d1c6f87c839d87caf2b8bc11f915bc,
          128'h6d88a37a110b3efddbf98641ca0093fd,
          128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
          128'head27321b58dbad2312bf5607f8d292f,
          128'hac7766f319fadc2128d12941575c006e,
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6},
        '{128'h00000000000000000000000000000000,
          128'h62636363626363636263636362636363,
          128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
          128'h90973450696ccffaf2f457330b0fac99,
          128'hee06da7b876a1581759e42b27e91ee2b,
          128'h7f2e2b88f8443e098dda7cbbf34b9290,
          128'hec614b851425758c99ff09376ab49ba7,
          128'h217517873550620bacaf6b3cc61bf09b,
          128'h0ef903333ba9613897060a04511dfa9f,
          128'hb1d4d8e28a7db9da1d7bb3de4c664941,
          128'hb4ef5bcb3e92e21123e951cf6f8f188e}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] key);
        kx_if.key_in       = key;
        kx_if.key_valid_in = 1'b1;
        step();
        kx_if.key_valid_in = 1'b0;
    endtask

    // Walks one sequence already loaded (round 0 visible now). Optionally
    // throttles ready, pulses a foreign key at inject_at, and holds a new key
    // valid across the final handshake so the caller can load it next cycle.
    task automatic run_seq(input int tbl, input bit throttle, input int inject_at,
                           input bit reload, input logic [127:0] reload_key);
        int r      = 0;
        int cyc    = 0;
        int stalls = 0;
        bit rdy;
        while (r <= 10 && cyc < 300) begin
            chk($sformatf("valid_r%0d", r), {127'b0, kx_if.key_valid_out}, 128'd1);
            chk($sformatf("key_r%0d", r), kx_if.key_out, exp_k[tbl][r]);
            chk($sformatf("round_r%0d", r), {124'b0, kx_if.key_round}, 128'(r));
            chk($sformatf("last_r%0d", r), {127'b0, kx_if.last_key}, 128'(r == 10));
            rdy = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
            kx_if.key_ready_in = rdy;
            kx_if.key_valid_in = 1'b0;
            if (r == inject_at) begin
                kx_if.key_valid_in = 1'b1;
                kx_if.key_in       = KEY_ALT;
            end
            if (reload && r == 10) begin
                kx_if.key_valid_in = 1'b1;
                kx_if.key_in       = reload_key;
            end
            step();
            cyc++;
            if (rdy) r++;
            else stalls++;
        end
        if (!reload) kx_if.key_valid_in = 1'b0;
        kx_if.key_ready_in = 1'b1;
        chk("seq_done", 128'(r), 128'd11);
        chk("seq_cycles", 128'(cyc), 128'(11 + stalls));
        chk("end_valid", {127'b0, kx_if.key_valid_out}, 128'd0);
        chk("end_busy", {127'b0, kx_if.busy}, 128'd0);
        chk("end_last", {127'b0, kx_if.last_key}, 128'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        kx_if.key_valid_in = 1'b0;
        kx_if.key_in       = '0;
        kx_if.key_ready_in = 1'b1;
        step();
        step();

        chk("rst_key_out", kx_if.key_out, 128'd0);
        chk("rst_valid", {127'b0, kx_if.key_valid_out}, 128'd0);
        chk("rst_round", {124'b0, kx_if.key_round}, 128'd0);
        chk("rst_last", {127'b0, kx_if.last_key}, 128'd0);
        chk("rst_busy", {127'b0, kx_if.busy}, 128'd0);

        #2 reset = 1'b0;
        step();
        chk("idle_ready_no_effect", {127'b0, kx_if.key_valid_out}, 128'd0);

        // FIPS key, ready high, with the zero key held valid across the final handshake.
        load(KEY_FIPS);
        run_seq(0, 1'b0, -1, 1'b1, KEY_ZERO);
        step();
        kx_if.key_valid_in = 1'b0;

        // Zero key, throttled, foreign key pulsed at round 4; FIPS reloaded after.
        run_seq(1, 1'b1, 4, 1'b1, KEY_FIPS);
        step();
        kx_if.key_valid_in = 1'b0;

        // FIPS again, throttled: rcon must have restarted.
        run_seq(0, 1'b1, -1, 1'b0, '0);

        // Reset mid-sequence at round 6.
        load(KEY_FIPS);
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_round", {124'b0, kx_if.key_round}, 128'd6);
        chk("pre_rst_key", kx_if.key_out, exp_k[0][6]);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_key_out", kx_if.key_out, 128'd0);
        chk("mid_rst_valid", {127'b0, kx_if.key_valid_out}, 128'd0);
        chk("mid_rst_round", {124'b0, kx_if.key_round}, 128'd0);
        chk("mid_rst_last", {127'b0, kx_if.last_key}, 128'd0);
        chk("mid_rst_busy", {127'b0, kx_if.busy}, 128'd0);
        step();
        #2 reset = 1'b0;
        step();
        chk("post_rst_valid", {127'b0, kx_if.key_valid_out}, 128'd0);

        load(KEY_ZERO);
        run_seq(1, 1'b0, -1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
